// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int LATENCY_MAX = 15;
  localparam logic [WORD_W-1:0] MMIO_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request/response bundle between the datapath and the responder.
interface data_mem_responder_if;
  logic [mem_pkg::WORD_W-1:0] addr;
  logic [mem_pkg::WORD_W-1:0] write_data;
  logic                       mem_write;
  logic                       mem_read;
  logic [mem_pkg::WORD_W-1:0] readdata;
  logic                       mem_stall;
  logic                       misalign_err;

  modport master (
    output addr, write_data, mem_write, mem_read,
    input  readdata, mem_stall, misalign_err
  );

  modport slave (
    input  addr, write_data, mem_write, mem_read,
    output readdata, mem_stall, misalign_err
  );
endinterface

// File: rtl/mem_wait_counter.sv
// 4-bit loadable down-counter timing the BUSY wait states; saturates at zero.
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM with LATENCY wait states and a pipeline stall output.
// Optional MMIO output register enabled by DATA_MEM_MMIO_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
`ifdef DATA_MEM_MMIO_EN
  ,
  output logic [WORD_W-1:0]     mmio_out
`endif
);
  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  state_t            state, state_nx;
  logic              req, start, fire, cnt_zero;
  logic [IDX_W-1:0]  cap_idx;
  logic [1:0]        cap_off;
  logic [WORD_W-1:0] cap_data;
  logic              cap_we;
  logic              cap_mmio;
  logic [WORD_W-1:0] rd_q;
  logic [WORD_W-1:0] mem [DEPTH];

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: if (req) begin
        start    = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (cnt_zero) begin
        fire     = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .en       (state == BUSY),
    .load_val (4'(LATENCY - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_idx  <= '0;
      cap_off  <= '0;
      cap_data <= '0;
      cap_we   <= 1'b0;
      cap_mmio <= 1'b0;
    end else if (start) begin
      cap_idx  <= bus.addr[IDX_W+1:2];
      cap_off  <= bus.addr[1:0];
      cap_data <= bus.write_data;
      cap_we   <= bus.mem_write;
`ifdef DATA_MEM_MMIO_EN
      cap_mmio <= (bus.addr == MMIO_ADDR);
`else
      cap_mmio <= 1'b0;
`endif
    end
  end

  // State is already IDLE while reset is high, so an abandoned write never fires.
  always_ff @(posedge clk) begin
    if (fire && cap_we && !cap_mmio) mem[cap_idx] <= cap_data;
  end

`ifdef DATA_MEM_MMIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         mmio_out <= '0;
    else if (fire && cap_we && cap_mmio) mmio_out <= cap_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else if (fire && !cap_we) begin
`ifdef DATA_MEM_MMIO_EN
      rd_q <= cap_mmio ? mmio_out : mem[cap_idx];
`else
      rd_q <= mem[cap_idx];
`endif
    end
  end

  assign bus.readdata     = rd_q;
  assign bus.mem_stall    = req & (state != DONE);
  assign bus.misalign_err = (cap_off != 2'b00) & (state == DONE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: three responders (LATENCY 2, 1, 15) against an array reference model.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int NDUT = 3;
`ifdef DATA_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  logic [31:0] drv_addr [NDUT];
  logic [31:0] drv_data [NDUT];
  logic        drv_we   [NDUT];
  logic        drv_re   [NDUT];
  logic        stall_v  [NDUT];
  logic        mis_v    [NDUT];
  logic [31:0] rd_v     [NDUT];
  logic [31:0] mmio_v   [NDUT];

  logic [31:0] ref_mem  [NDUT][64];
  logic [31:0] ref_rd   [NDUT];
  logic [31:0] ref_mmio [NDUT];
  int          last_done[NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].addr       = drv_addr[g];
    assign bus[g].write_data = drv_data[g];
    assign bus[g].mem_write  = drv_we[g];
    assign bus[g].mem_read   = drv_re[g];
    assign stall_v[g]        = bus[g].mem_stall;
    assign mis_v[g]          = bus[g].misalign_err;
    assign rd_v[g]           = bus[g].readdata;
`ifndef DATA_MEM_MMIO_EN
    assign mmio_v[g]         = '0;
`endif

    data_mem_responder #(
      .DEPTH   (64),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus[g])
`ifdef DATA_MEM_MMIO_EN
      ,
      .mmio_out (mmio_v[g])
`endif
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete access; entered and left at posedge+1 of an IDLE cycle.
  task automatic access(input int k, input bit we, input bit re,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit pert, input bit b2b);
    int          n;
    int          idx;
    bit          is_m;
    drv_addr[k] = a;
    drv_data[k] = d;
    drv_we[k]   = we;
    drv_re[k]   = re;
    n = 0;
    #1;
    while (stall_v[k] && n < 60) begin
      n++;
      @(posedge clk); #1;
      if (pert) begin
        drv_addr[k] = $urandom;
        drv_data[k] = $urandom;
      end
      #1;
    end
    check_eq("stall_cycles", n, lat(k) + 1);
    if (b2b) check_eq("done_gap", cyc - last_done[k], lat(k) + 2);
    last_done[k] = cyc;

    is_m = MMIO_EN && (a == MMIO_ADDR);
    idx  = (a / 4) % 64;
    if (we) begin
      if (is_m) ref_mmio[k] = d;
      else      ref_mem[k][idx] = d;
    end else begin
      ref_rd[k] = is_m ? ref_mmio[k] : ref_mem[k][idx];
    end
    check_eq("readdata", rd_v[k], ref_rd[k]);
    check_eq("misalign_done", {31'b0, mis_v[k]}, {31'b0, (a % 4) != 0});
    if (MMIO_EN) check_eq("mmio_out", mmio_v[k], ref_mmio[k]);

    @(posedge clk); #1;
    check_eq("misalign_after", {31'b0, mis_v[k]}, 32'd0);
    drv_we[k] = 1'b0;
    drv_re[k] = 1'b0;
  endtask

  task automatic clear_model_rd();
    for (int i = 0; i < NDUT; i++) ref_rd[i] = '0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NDUT; i++) begin
      drv_addr[i] = '0; drv_data[i] = '0; drv_we[i] = 1'b0; drv_re[i] = 1'b0;
      ref_rd[i] = '0; ref_mmio[i] = '0; last_done[i] = 0;
    end
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_eq("reset_readdata", rd_v[i], 32'd0);
      check_eq("reset_misalign", {31'b0, mis_v[i]}, 32'd0);
      check_eq("reset_stall", {31'b0, stall_v[i]}, 32'd0);
      if (MMIO_EN) check_eq("reset_mmio", mmio_v[i], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Fill every RAM so all later reads have a known expectation.
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 64; i++)
        access(k, 1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0);

    // Directed write/read, wrap-around, misalignment on LATENCY=2.
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    check_eq("rd_deadbeef", rd_v[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h100, 32'h1234, 1'b0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h000, 32'h0, 1'b0, 1'b0);
    check_eq("rd_wrap", rd_v[0], 32'h1234);
    access(0, 1'b1, 1'b0, 32'h10, 32'h4444_0004, 1'b0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0, 1'b0);
    check_eq("rd_misaligned", rd_v[0], 32'h4444_0004);
    access(0, 1'b1, 1'b1, 32'h10, 32'h7777_7777, 1'b0, 1'b0);

    // Reset during BUSY abandons the pending write.
    access(0, 1'b1, 1'b0, 32'h20, 32'h5, 1'b0, 1'b0);
    drv_addr[0] = 32'h20; drv_data[0] = 32'hAAAA_AAAA; drv_we[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("busy_stall", {31'b0, stall_v[0]}, 32'd1);
    reset = 1'b1;
    #1;
    drv_we[0] = 1'b0;
    #1;
    clear_model_rd();
    for (int i = 0; i < NDUT; i++) check_eq("rst_busy_rd", rd_v[i], 32'd0);
    check_eq("rst_busy_stall", {31'b0, stall_v[0]}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    check_eq("rd_after_abandon", rd_v[0], 32'h5);

    // Reset during DONE clears readdata.
    drv_addr[1] = 32'h20; drv_re[1] = 1'b1;
    n = 0;
    #1;
    while (stall_v[1] && n < 60) begin n++; @(posedge clk); #2; end
    check_eq("pre_done_stalls", n, 2);
    reset = 1'b1;
    #1;
    drv_re[1] = 1'b0;
    clear_model_rd();
    check_eq("rst_done_rd", rd_v[1], 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back loads with the address perturbed after capture.
    for (int k = 0; k < NDUT; k++) begin
      access(k, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
      access(k, 1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 1'b1);
      access(k, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 1'b1);
    end

    // MMIO address: register when enabled, RAM index 60 otherwise.
    access(0, 1'b1, 1'b0, MMIO_ADDR, 32'hCAFE, 1'b0, 1'b0);
    access(0, 1'b0, 1'b1, 32'hF0, 32'h0, 1'b0, 1'b0);
    if (!MMIO_EN) check_eq("rd_mmio_alias", rd_v[0], 32'hCAFE);
    access(0, 1'b0, 1'b1, MMIO_ADDR, 32'h0, 1'b0, 1'b0);
    check_eq("rd_mmio_addr", rd_v[0], 32'hCAFE);

    // Randomized traffic, including read-after-write and back-to-back runs.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NDUT; k++) begin
        logic [31:0] a;
        bit we, re;
        a  = (r % 8 == 0) ? MMIO_ADDR : $urandom;
        we = $urandom_range(0, 1) == 1;
        re = we ? ($urandom_range(0, 3) == 0) : 1'b1;
        access(k, we, re, a, $urandom, $urandom_range(0, 1) == 1, 1'b0);
        if (we) access(k, 1'b0, 1'b1, a, 32'h0, 1'b0, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
